df_filter_sequencer: RTL and testbench

Self-test sequencer that drives the programming and sample ports of the 4-tap digital filter and observes its result port. On a start request it:

- writes a 3-bit configuration word through the filter's slow, synchronised config port;
- streams a selectable test pattern into the data port, followed by zero flush samples;
- captures the filter outputs and reduces them to a wrapping sum and an unsigned peak.

It sits beside the filter in the macro as its on-chip stimulus and response source.

---
 rtl/df_filter_sequencer_pkg.sv | 27 ++
 rtl/df_seq_pattern_gen.sv | 25 ++
 rtl/df_filter_sequencer.sv | 145 ++++++++++++++
 tb/tb_df_filter_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/df_filter_sequencer_pkg.sv
// Shared definitions for the filter self-test sequencer: state encodings,
// pattern codes and default parameter values.
package df_filter_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CFG_SETUP = 3'd1,
      CFG_PULSE = 3'd2,
      CFG_HOLD  = 3'd3,
      STREAM    = 3'd4,
      DRAIN     = 3'd5,
      DONE      = 3'd6
   } state_t;

   localparam logic [1:0] PAT_IMPULSE = 2'd0;
   localparam logic [1:0] PAT_STEP    = 2'd1;
   localparam logic [1:0] PAT_RAMP    = 2'd2;
   localparam logic [1:0] PAT_ALT     = 2'd3;

   localparam int DEF_HOLD_CYCLES = 3;
   localparam int DEF_LATENCY     = 4;
   localparam int DEF_FLUSH       = 3;

   // Wide enough for the longest stream phase (255 samples + flush).
   localparam int CNT_W = 10;

endpackage

// File: rtl/df_seq_pattern_gen.sv
// Combinational test-pattern source: sample value for index k of the
// selected pattern, forced to zero while flushing the filter taps.
module df_seq_pattern_gen
   import df_filter_sequencer_pkg::*;
(
   input  logic [1:0] pattern,
   input  logic [7:0] k,
   input  logic       flush,
   output logic [7:0] sample
);

   always_comb begin
      sample = 8'h00;
      if (!flush) begin
         case (pattern)
            PAT_IMPULSE: sample = (k == 8'd0) ? 8'hFF : 8'h00;
            PAT_STEP:    sample = 8'h80;
            PAT_RAMP:    sample = k;
            PAT_ALT:     sample = k[0] ? 8'h00 : 8'hFF;
            default:     sample = 8'h00;
         endcase
      end
   end

endmodule

// File: rtl/df_filter_sequencer.sv
// Self-test sequencer for the 4-tap filter: programs the config port, streams
// a test pattern plus flush zeros, and reduces the responses to sum and peak.
module df_filter_sequencer
   import df_filter_sequencer_pkg::*;
#(
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int LATENCY     = DEF_LATENCY,
   parameter int FLUSH       = DEF_FLUSH
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        start,
   input  logic [2:0]  mode,
   input  logic [1:0]  pattern,
   input  logic [7:0]  nsamples,
   output logic        enconfig,
   output logic [2:0]  configin,
   output logic [7:0]  datain,
   input  logic [7:0]  dataout,
   output logic        busy,
   output logic        done,
   output logic [15:0] sum,
   output logic [7:0]  peak
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(LATENCY - 1);

   state_t             state, state_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic [1:0]         pat_r;
   logic [7:0]         n_r;
   logic [LATENCY-1:0] vld_p;
   logic [CNT_W-1:0]   stream_last;
   logic               accept;
   logic               flush;
   logic [7:0]         sample;

   function automatic logic [15:0] wrap_add(input logic [15:0] a, input logic [7:0] b);
      return a + {8'b0, b};
   endfunction

   function automatic logic [7:0] max_u8(input logic [7:0] a, input logic [7:0] b);
      return (b > a) ? b : a;
   endfunction

   assign accept      = (state == IDLE) && start;
   assign stream_last = CNT_W'(n_r) + CNT_W'(FLUSH) - 1'b1;
   assign flush       = (cnt_next >= CNT_W'(n_r));

   df_seq_pattern_gen u_pattern_gen (
      .pattern (pat_r),
      .k       (cnt_next[7:0]),
      .flush   (flush),
      .sample  (sample)
   );

   // cnt counts cycles spent in the current state; cnt_next doubles as the
   // sample index for the cycle being loaded into datain.
   always_comb begin
      state_next = state;
      cnt_next   = cnt + 1'b1;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (start) state_next = CFG_SETUP;
         end
         CFG_SETUP: begin
            cnt_next   = '0;
            state_next = CFG_PULSE;
         end
         CFG_PULSE: begin
            if (cnt == HOLD_LAST) begin
               cnt_next   = '0;
               state_next = CFG_HOLD;
            end
         end
         CFG_HOLD: begin
            if (cnt == HOLD_LAST) begin
               cnt_next   = '0;
               state_next = (n_r == 8'd0) ? DONE : STREAM;
            end
         end
         STREAM: begin
            if (cnt == stream_last) begin
               cnt_next   = '0;
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (cnt == LAT_LAST) begin
               cnt_next   = '0;
               state_next = DONE;
            end
         end
         DONE: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
         default: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the
   // state they belong to.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= IDLE;
         cnt      <= '0;
         pat_r    <= '0;
         n_r      <= '0;
         vld_p    <= '0;
         enconfig <= 1'b0;
         configin <= 3'b000;
         datain   <= 8'h00;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= 16'h0000;
         peak     <= 8'h00;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         enconfig <= (state_next == CFG_PULSE);
         busy     <= (state_next != IDLE) && (state_next != DONE);
         done     <= (state_next == DONE);
         datain   <= (state_next == STREAM) ? sample : 8'h00;
         vld_p[0] <= (state == STREAM);
         for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
         if (accept) begin
            configin <= mode;
            pat_r    <= pattern;
            n_r      <= nsamples;
            sum      <= 16'h0000;
            peak     <= 8'h00;
         end else if (vld_p[LATENCY-1]) begin
            sum      <= wrap_add(sum, dataout);
            peak     <= max_u8(peak, dataout);
         end
      end
   end

endmodule

// File: tb/tb_df_filter_sequencer.sv
// Bench for df_filter_sequencer with a 4-register loopback filter stub.
module tb_df_filter_sequencer;

   localparam int H = 3;
   localparam int L = 4;
   localparam int F = 3;

   logic        CLK;
   logic        nRST;
   logic        start;
   logic [2:0]  mode;
   logic [1:0]  pattern;
   logic [7:0]  nsamples;
   logic        enconfig;
   logic [2:0]  configin;
   logic [7:0]  datain;
   logic [7:0]  dataout;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic [7:0]  peak;

   logic [7:0]  d1, d2, d3, d4;

   int total = 0;
   int bad   = 0;

   df_filter_sequencer #(
      .HOLD_CYCLES (H),
      .LATENCY     (L),
      .FLUSH       (F)
   ) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .start    (start),
      .mode     (mode),
      .pattern  (pattern),
      .nsamples (nsamples),
      .enconfig (enconfig),
      .configin (configin),
      .datain   (datain),
      .dataout  (dataout),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .peak     (peak)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always_ff @(posedge CLK) begin
      d1 <= datain;
      d2 <= d1;
      d3 <= d2;
      d4 <= d3;
   end
   assign dataout = d4;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_sample(input int p, input int k);
      case (p)
         0: return (k == 0) ? 255 : 0;
         1: return 128;
         2: return k % 256;
         default: return (k % 2 == 0) ? 255 : 0;
      endcase
   endfunction

   // One complete run from start to the idle cycle after done, checked cycle by cycle.
   task automatic run(input logic [2:0] m, input int p, input int n, input bit disturb);
      int s0, done_c, exp_sum, exp_peak, v, exp_d;
      s0       = 2 + 2*H;
      done_c   = (n == 0) ? s0 : s0 + n + F + L;
      exp_sum  = 0;
      exp_peak = 0;
      for (int k = 0; k < n; k++) begin
         v = ref_sample(p, k);
         exp_sum += v;
         if (v > exp_peak) exp_peak = v;
      end
      exp_sum = exp_sum % 65536;

      @(negedge CLK);
      start    = 1'b1;
      mode     = m;
      pattern  = p[1:0];
      nsamples = n[7:0];
      for (int c = 1; c <= done_c + 1; c++) begin
         @(negedge CLK);
         check($sformatf("enconfig@%0d", c), {31'b0, enconfig}, {31'b0, (c >= 2 && c <= 1 + H)});
         check($sformatf("configin@%0d", c), {29'b0, configin}, {29'b0, m});
         check($sformatf("busy@%0d", c), {31'b0, busy}, {31'b0, (c < done_c)});
         check($sformatf("done@%0d", c), {31'b0, done}, {31'b0, (c == done_c)});
         exp_d = (c >= s0 && c < s0 + n) ? ref_sample(p, c - s0) : 0;
         check($sformatf("datain@%0d", c), {24'b0, datain}, exp_d);
         if (c == 1) begin
            check("sum_cleared", {16'b0, sum}, 0);
            check("peak_cleared", {24'b0, peak}, 0);
         end
         if (c >= done_c) begin
            check($sformatf("sum@%0d", c), {16'b0, sum}, exp_sum);
            check($sformatf("peak@%0d", c), {24'b0, peak}, exp_peak);
         end
         if (c == 1) start = 1'b0;
         if (disturb && c == 6) begin
            start    = 1'b1;
            mode     = ~m;
            pattern  = pattern + 2'd1;
            nsamples = 8'($urandom);
         end
         if (disturb && c == 7) start = 1'b0;
      end
   endtask

   initial begin
      nRST     = 1'b0;
      start    = 1'b0;
      mode     = 3'b000;
      pattern  = 2'd0;
      nsamples = 8'd0;
      repeat (2) @(negedge CLK);
      check("rst_enconfig", {31'b0, enconfig}, 0);
      check("rst_configin", {29'b0, configin}, 0);
      check("rst_datain", {24'b0, datain}, 0);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_done", {31'b0, done}, 0);
      check("rst_sum", {16'b0, sum}, 0);
      check("rst_peak", {24'b0, peak}, 0);
      nRST = 1'b1;
      @(negedge CLK);

      run(3'b101, 0, 0, 1'b0);
      run(3'b010, 2, 4, 1'b0);
      run(3'b111, 0, 4, 1'b0);
      run(3'b001, 1, 2, 1'b0);
      run(3'b110, 3, 255, 1'b1);

      for (int r = 0; r < 6; r++)
         run(3'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 40)), 1'($urandom));

      // Abort a step run mid-stream, then confirm a fresh run carries no residue.
      @(negedge CLK);
      start    = 1'b1;
      mode     = 3'b011;
      pattern  = 2'd1;
      nsamples = 8'd20;
      @(negedge CLK);
      start = 1'b0;
      repeat (12) @(negedge CLK);
      check("abort_busy", {31'b0, busy}, 1);
      check("abort_sum", {16'b0, sum}, 128);
      nRST = 1'b0;
      #1;
      check("arst_enconfig", {31'b0, enconfig}, 0);
      check("arst_configin", {29'b0, configin}, 0);
      check("arst_datain", {24'b0, datain}, 0);
      check("arst_busy", {31'b0, busy}, 0);
      check("arst_done", {31'b0, done}, 0);
      check("arst_sum", {16'b0, sum}, 0);
      check("arst_peak", {24'b0, peak}, 0);
      repeat (2) @(negedge CLK);
      nRST = 1'b1;
      run(3'b100, 0, 1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
